// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl
// Front-end pipeline sequencer that resolves, in priority order, taken-branch
// redirects, load-use hazards and instruction-memory waits, and keeps a
// saturating stall-cycle counter.
// Revision: 1.0
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REGW              = 4,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int BRANCH_PENALTY    = 2
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic            ex_mem_read,
    input  logic [REGW-1:0] ex_rd,
    input  logic            ex_branch_taken,
    input  logic            imem_ready,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic [15:0]     stall_cycles
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        BR_FLUSH   = 2'd2,
        IMEM_WAIT  = 2'd3
    } state_t;

    // The first penalty cycle is the redirect/hazard cycle itself, hence -2.
    localparam logic [3:0] C_LOAD_CNT = (LOAD_STALL_CYCLES > 1) ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;
    localparam logic [3:0] C_BR_CNT   = (BRANCH_PENALTY > 1)    ? 4'(BRANCH_PENALTY - 2)    : 4'd0;
    localparam logic [15:0] C_STALL_MAX = 16'hFFFF;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_q;

    logic w_hz_load;
    logic w_pc_write, w_ifid_write, w_ifid_flush, w_idex_flush;

    assign w_hz_load = ex_mem_read && (ex_rd != '0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        w_pc_write   = 1'b1;
        w_ifid_write = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;

        if (ex_branch_taken) begin
            w_ifid_write = 1'b0;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            state_d      = (BRANCH_PENALTY > 1) ? BR_FLUSH : RUN;
            cnt_d        = C_BR_CNT;
        end else begin
            case (state_q)
                RUN: begin
                    if (w_hz_load) begin
                        w_pc_write   = 1'b0;
                        w_ifid_write = 1'b0;
                        w_idex_flush = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = LOAD_STALL;
                            cnt_d   = C_LOAD_CNT;
                        end
                    end else if (!imem_ready) begin
                        w_pc_write   = 1'b0;
                        w_ifid_write = 1'b0;
                        w_idex_flush = 1'b1;
                        state_d      = IMEM_WAIT;
                    end
                end
                LOAD_STALL: begin
                    w_pc_write   = 1'b0;
                    w_ifid_write = 1'b0;
                    w_idex_flush = 1'b1;
                    if (cnt_q == 4'd0) state_d = RUN;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                BR_FLUSH: begin
                    w_pc_write   = imem_ready;
                    w_ifid_write = 1'b0;
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                    if (cnt_q == 4'd0) state_d = RUN;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                IMEM_WAIT: begin
                    // ID is frozen here, so a pending load hazard is picked up back in RUN.
                    if (imem_ready) begin
                        state_d = RUN;
                    end else begin
                        w_pc_write   = 1'b0;
                        w_ifid_write = 1'b0;
                        w_idex_flush = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!w_ifid_write && (stall_q != C_STALL_MAX))
                stall_q <= stall_q + 16'd1;
        end
    end

    // Reset overrides the decoded controls without waiting for a clock edge.
    assign pc_write     = Reset & w_pc_write;
    assign ifid_write   = Reset & w_ifid_write;
    assign ifid_flush   = ~Reset | w_ifid_flush;
    assign idex_flush   = ~Reset | w_idex_flush;
    assign stall_cycles = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipe_hazard_ctrl
// Directed-vector bench with an expectation queue and a decoupled monitor.
// Revision: 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [3:0] rd;
        logic       br;
        logic       rdy;
        logic       rstn;
    } vin_t;

    typedef struct packed {
        logic [15:0] id;
        logic [3:0]  ctl;   // {pc_write, ifid_write, ifid_flush, idex_flush}
        logic [15:0] st;
    } exp_t;

    localparam logic [3:0] NORM = 4'b1100;
    localparam logic [3:0] BUB  = 4'b0001;
    localparam logic [3:0] BRX  = 4'b1011;
    localparam logic [3:0] BRF0 = 4'b0011;
    localparam logic [3:0] RSTV = 4'b0011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] id_rs1 = 4'd1, id_rs2 = 4'd2, ex_rd = 4'd0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_mem_read = 1'b0;
    logic       ex_branch_taken = 1'b0, imem_ready = 1'b1;
    logic       pc_write, ifid_write, ifid_flush, idex_flush;
    logic [15:0] stall_cycles;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   vec_id = 0;

    pipe_hazard_ctrl #(.REGW(4), .LOAD_STALL_CYCLES(1), .BRANCH_PENALTY(2)) dut (
        .CLK(clk), .Reset(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic vin_t mk(input logic [3:0] rs1, input logic [3:0] rs2,
                                input logic u1, input logic u2, input logic mr,
                                input logic [3:0] rd, input logic br,
                                input logic rdy, input logic rstn);
        vin_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.mr = mr;
        v.rd = rd; v.br = br; v.rdy = rdy; v.rstn = rstn;
        return v;
    endfunction

    // Common patterns: idle, load-use on rs2==3, and variants.
    function automatic vin_t idle(input logic br, input logic rdy, input logic rstn);
        return mk(4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 4'd0, br, rdy, rstn);
    endfunction

    function automatic vin_t hz(input logic br, input logic rdy);
        return mk(4'd1, 4'd3, 1'b0, 1'b1, 1'b1, 4'd3, br, rdy, 1'b1);
    endfunction

    task automatic drive(input vin_t v);
        @(posedge clk);
        #1;
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
        ex_mem_read = v.mr; ex_rd = v.rd; ex_branch_taken = v.br;
        imem_ready = v.rdy; rst_n = v.rstn;
    endtask

    task automatic step(input vin_t v, input logic [3:0] ctl, input logic [15:0] st);
        exp_t e;
        drive(v);
        e.id = 16'(vec_id); e.ctl = ctl; e.st = st;
        exp_q.push_back(e);
        vec_id++;
    endtask

    // Monitor: compares on the falling edge, away from the input/state updates.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [3:0] act;
            e   = exp_q.pop_front();
            act = {pc_write, ifid_write, ifid_flush, idex_flush};
            n_cmp++;
            if (act !== e.ctl || stall_cycles !== e.st) begin
                n_err++;
                $display("FAIL vec%0d: ctl(pc,ifw,iff,idf)=%b stall=%h, expected ctl=%b stall=%h",
                         e.id, act, stall_cycles, e.ctl, e.st);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for 3 cycles, then released.
        for (int i = 0; i < 3; i++) step(idle(1'b0, 1'b1, 1'b0), RSTV, 16'd0);
        step(idle(1'b0, 1'b1, 1'b1), NORM, 16'd0);
        step(idle(1'b0, 1'b1, 1'b1), NORM, 16'd0);

        // Load-use on rs2: one bubble cycle.
        step(hz(1'b0, 1'b1), BUB, 16'd0);
        step(idle(1'b0, 1'b1, 1'b1), NORM, 16'd1);

        // Register 0, unused operand and non-load never stall.
        step(mk(4'd1, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1), NORM, 16'd1);
        step(mk(4'd5, 4'd2, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b1), NORM, 16'd1);
        step(mk(4'd5, 4'd2, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b1), BUB,  16'd1);
        step(idle(1'b0, 1'b1, 1'b1), NORM, 16'd2);
        step(mk(4'd5, 4'd2, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1, 1'b1), NORM, 16'd2);

        // Taken branch: redirect then one BR_FLUSH cycle.
        step(idle(1'b1, 1'b1, 1'b1), BRX,  16'd2);
        step(idle(1'b0, 1'b1, 1'b1), BRX,  16'd3);
        step(idle(1'b0, 1'b1, 1'b1), NORM, 16'd4);

        // Branch wins over a simultaneous load hazard; BR_FLUSH gates pc_write on imem_ready.
        step(hz(1'b1, 1'b0), BRX, 16'd4);
        step(idle(1'b0, 1'b0, 1'b1), BRF0, 16'd5);
        step(idle(1'b0, 1'b1, 1'b1), NORM, 16'd6);

        // imem_ready low 4 cycles with a branch in the 3rd.
        step(idle(1'b0, 1'b0, 1'b1), BUB,  16'd6);
        step(idle(1'b0, 1'b0, 1'b1), BUB,  16'd7);
        step(idle(1'b1, 1'b0, 1'b1), BRX,  16'd8);
        step(idle(1'b0, 1'b0, 1'b1), BRF0, 16'd9);
        step(idle(1'b0, 1'b1, 1'b1), NORM, 16'd10);

        // Load hazard seen while in IMEM_WAIT is deferred to RUN.
        step(idle(1'b0, 1'b0, 1'b1), BUB,  16'd10);
        step(hz(1'b0, 1'b1),         NORM, 16'd11);
        step(hz(1'b0, 1'b1),         BUB,  16'd11);
        step(idle(1'b0, 1'b1, 1'b1), NORM, 16'd12);

        // Reset asserted mid-BR_FLUSH, between clock edges.
        step(idle(1'b1, 1'b1, 1'b1), BRX,  16'd12);
        step(idle(1'b0, 1'b1, 1'b0), RSTV, 16'd0);
        step(idle(1'b0, 1'b1, 1'b0), RSTV, 16'd0);
        step(idle(1'b0, 1'b1, 1'b1), NORM, 16'd0);

        // Saturation: 0xFFFE unchecked stall cycles, then observe the ceiling.
        for (int i = 0; i < 16'hFFFE; i++) drive(idle(1'b0, 1'b0, 1'b1));
        step(idle(1'b0, 1'b0, 1'b1), BUB, 16'hFFFE);
        step(idle(1'b0, 1'b0, 1'b1), BUB, 16'hFFFF);
        step(idle(1'b0, 1'b0, 1'b1), BUB, 16'hFFFF);
        step(idle(1'b0, 1'b1, 1'b1), NORM, 16'hFFFF);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer for the 16-bit core's front end.
- Generates the IF/ID write enable (the IF/ID register's RegWrite), the PC write enable, the IF/ID flush and the ID/EX bubble.
- Resolves three event types in a fixed priority: taken-branch redirect, load-use hazard, and instruction-memory wait.
- Keeps a saturating count of front-end stall cycles for performance debug.

Parameters:
- REGW, 4: register-specifier width.
- LOAD_STALL_CYCLES, 1: bubbles inserted per load-use hazard (1..15).
- BRANCH_PENALTY, 2: cycles IF/ID is flushed per taken branch (1..15).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- id_rs1  in  REGW  source register 1 of the instruction in ID.
- id_rs2  in  REGW  source register 2 of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  REGW  destination register of the EX instruction.
- ex_branch_taken  in  1  one-cycle pulse: EX resolved a taken branch/jump.
- imem_ready  in  1  instruction memory has valid data this cycle.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID register write enable.
- ifid_flush  out  1  clear IF/ID to 0x0000 (NOP).
- idex_flush  out  1  insert bubble into ID/EX.
- stall_cycles  out  16  saturating count of cycles with ifid_write=0.

Behaviour:
- States: RUN, LOAD_STALL, BR_FLUSH, IMEM_WAIT.
- Down-counter cnt is 4 bits.
- Outputs are combinational from the current state and inputs. State, cnt and stall_cycles are registered.
- While Reset=0:
  - state=RUN, cnt=0, stall_cycles=0.
  - Outputs forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1.
  - Release of Reset takes effect at the next rising CLK.
- Hazard definitions:
  - hz_load = ex_mem_read & (ex_rd≠0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Register 0 never causes a hazard.
- Priority in every state: ex_branch_taken > hz_load > !imem_ready.
- Branch (any state, ex_branch_taken=1):
  - Outputs: pc_write=1, ifid_write=0, ifid_flush=1, idex_flush=1.
  - If BRANCH_PENALTY>1: next state BR_FLUSH with cnt=BRANCH_PENALTY-2. Otherwise next state RUN.
  - A branch aborts any LOAD_STALL or IMEM_WAIT in progress.
- RUN, no branch, hz_load:
  - Outputs: pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1.
  - If LOAD_STALL_CYCLES>1: next state LOAD_STALL with cnt=LOAD_STALL_CYCLES-2. Otherwise stay in RUN.
- RUN, no branch, no hz_load, imem_ready=0:
  - Outputs: pc_write=0, ifid_write=0, idex_flush=1.
  - Next state IMEM_WAIT.
- RUN, otherwise:
  - Outputs: pc_write=1, ifid_write=1, flushes 0.
- LOAD_STALL:
  - Outputs same as the hz_load cycle.
  - cnt decrements each cycle; at cnt=0 go to RUN.
- BR_FLUSH:
  - Outputs: pc_write=imem_ready, ifid_write=0, ifid_flush=1, idex_flush=1.
  - cnt decrements; at cnt=0 go to RUN.
- IMEM_WAIT:
  - Outputs same as the imem-wait cycle while imem_ready=0.
  - On imem_ready=1: outputs as RUN-normal that cycle, then return to RUN.
  - A load hazard appearing while in IMEM_WAIT is handled on return to RUN, because ID is frozen.
- stall_cycles:
  - Increments on each rising edge where ifid_write=0 and Reset=1.
  - Holds at 0xFFFF.
- Asynchronous reset mid-stall or mid-flush: immediately abandons the state and clears cnt and stall_cycles.

Test Plan:
- Reset low 3 cycles, then high, no hazards, imem_ready=1 → during reset pc_write=0 and ifid_flush=1; first cycle after release pc_write=1, ifid_write=1; stall_cycles=0.
- ex_mem_read=1, ex_rd=3, id_rs2=3, id_use_rs2=1 for one cycle → exactly 1 cycle of ifid_write=0, pc_write=0, idex_flush=1; stall_cycles=1.
- Same stimulus with ex_rd=0 → no stall, ifid_write stays 1.
- ex_branch_taken pulse with the default penalty of 2 → 2 consecutive cycles of ifid_flush=1; pc_write=1 in the first cycle; then RUN with ifid_write=1.
- imem_ready=0 for 4 cycles, with a branch pulse in the 3rd cycle → cycles 1–2 bubble; cycle 3 redirect with pc_write=1; then BR_FLUSH; total stall_cycles=4.
- Force stall_cycles to 0xFFFE, then 3 stall cycles → value saturates at 0xFFFF. Assert Reset mid-BR_FLUSH → outputs go to reset values asynchronously.
